// File: rtl/rr_mux_feeder.sv
// rr_mux_feeder: upstream scheduler for a 4-to-1 WIDTH-bit mux.
//   Buffers one word per input channel (a..d), arbitrates round-robin among
//   the buffered words and presents the winner on sel/out_data with a
//   valid/ready handshake. sel drives the downstream mux select directly.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready[4]  per-channel handshake, bit0=a .. bit3=d
//   a, b, c, d            channel data
//   sel[2]                granted channel index (registered)
//   out_valid, out_data   granted word (registered)
//   out_ready             downstream accept

// One-entry channel buffer. Never captures while full, so a granted slot
// cannot be refilled on its grant edge.
module rr_slot #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_clr,
  output logic             o_full,
  output logic [WIDTH-1:0] o_data
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_full <= 1'b0;
      o_data <= '0;
    end else if (i_clr) begin
      o_full <= 1'b0;
    end else if (i_valid && !o_full) begin
      o_full <= 1'b1;
      o_data <= i_data;
    end
  end
endmodule

module rr_mux_feeder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [1:0]       sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);
  localparam int NUM_LANES = 4;

  typedef enum logic {S_EMPTY, S_HOLD} state_t;

  state_t                              r_state;
  logic [1:0]                          r_last;
  logic [NUM_LANES-1:0][WIDTH-1:0]     w_in;
  logic [NUM_LANES-1:0][WIDTH-1:0]     w_slot;
  logic [NUM_LANES-1:0]                w_full;
  logic [NUM_LANES-1:0]                w_clr;
  logic                                w_load;
  logic                                w_any;
  logic [1:0]                          w_win;

  assign w_in     = {d, c, b, a};
  assign in_ready = ~w_full;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    rr_slot #(.WIDTH(WIDTH)) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (in_valid[i]),
      .i_data  (w_in[i]),
      .i_clr   (w_clr[i]),
      .o_full  (w_full[i]),
      .o_data  (w_slot[i])
    );
  end

  // Output register is free when empty or being accepted this cycle.
  assign w_load = (r_state == S_EMPTY) | (out_valid & out_ready);

  // Round-robin: scan last+1, +2, +3, +0; first full slot wins.
  always_comb begin
    w_any = 1'b0;
    w_win = r_last;
    for (int k = 1; k <= NUM_LANES; k++) begin
      if (!w_any && w_full[2'(r_last + 2'(k))]) begin
        w_any = 1'b1;
        w_win = 2'(r_last + 2'(k));
      end
    end
  end

  always_comb begin
    w_clr = '0;
    if (w_load && w_any) w_clr[w_win] = 1'b1;
  end

  // sel/out_data only move on a load with a winner, so the mux select is
  // always a clean registered value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      sel       <= 2'b00;
      r_last    <= 2'b11;
    end else if (w_load) begin
      if (w_any) begin
        r_state   <= S_HOLD;
        out_valid <= 1'b1;
        out_data  <= w_slot[w_win];
        sel       <= w_win;
        r_last    <= w_win;
      end else begin
        r_state   <= S_EMPTY;
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rr_mux_feeder.sv
// Directed bench for rr_mux_feeder. Inputs change 1ns after the rising
// edge and outputs are sampled at that same point, so each check sees the
// state left by the edge just taken.
module tb_rr_mux_feeder;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_valid;
  logic [3:0] in_ready;
  logic [3:0] a, b, c, d;
  logic [1:0] sel;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_ready;

  int n_run  = 0;
  int n_fail = 0;

  rr_mux_feeder #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] s, input logic [3:0] dat);
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_sel"}, 32'(sel), 32'(s));
    chk({tag, "_dat"}, 32'(out_data), 32'(dat));
  endtask

  task automatic do_reset();
    in_valid = 4'b0000;
    rst_n    = 1'b0;
    step();
    rst_n    = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 4'b0000; out_ready = 1'b1;
    a = 4'h0; b = 4'h0; c = 4'h0; d = 4'h0;

    // Reset values, including in_ready during reset
    #2;
    chk("rst_rdy",  32'(in_ready), 32'hF);
    chk("rst_vld",  32'(out_valid), 32'd0);
    chk("rst_sel",  32'(sel), 32'd0);
    chk("rst_dat",  32'(out_data), 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("post_rst_rdy", 32'(in_ready), 32'hF);
    chk("post_rst_vld", 32'(out_valid), 32'd0);

    // Single word on channel 0
    a = 4'h5; in_valid = 4'b0001;
    step();
    chk("t1_rdy_cap", 32'(in_ready), 32'hE);
    chk("t1_vld_cap", 32'(out_valid), 32'd0);
    in_valid = 4'b0000;
    step();
    chk_out("t1_out", 2'd0, 4'h5);
    chk("t1_rdy_back", 32'(in_ready), 32'hF);
    step();
    chk("t1_drain", 32'(out_valid), 32'd0);

    // All four slots loaded at once, last_grant=3 after reset
    do_reset();
    a = 4'h1; b = 4'h2; c = 4'h3; d = 4'h4; in_valid = 4'b1111;
    step();
    chk("t2_rdy_full", 32'(in_ready), 32'h0);
    in_valid = 4'b0000;
    step(); chk_out("t2_g0", 2'd0, 4'h1);
    step(); chk_out("t2_g1", 2'd1, 4'h2);
    step(); chk_out("t2_g2", 2'd2, 4'h3);
    step(); chk_out("t2_g3", 2'd3, 4'h4);
    step(); chk("t2_drain", 32'(out_valid), 32'd0);

    // Channels 0 and 2 held valid: grants alternate 0,2,0,2
    a = 4'hA; c = 4'hC; in_valid = 4'b0101;
    step();
    chk("t3_cap_vld", 32'(out_valid), 32'd0);
    step(); chk_out("t3_g0", 2'd0, 4'hA);
    chk("t3_rdy", 32'(in_ready), 32'hB);
    step(); chk_out("t3_g1", 2'd2, 4'hC);
    chk("t3_rdy2", 32'(in_ready), 32'hE);
    step(); chk_out("t3_g2", 2'd0, 4'hA);
    step(); chk_out("t3_g3", 2'd2, 4'hC);
    do_reset();

    // Backpressure: 1/9 held for 5 cycles while c=7 is captured
    b = 4'h9; in_valid = 4'b0010;
    step();
    in_valid = 4'b0000; out_ready = 1'b0;
    step(); chk_out("t4_first", 2'd1, 4'h9);
    c = 4'h7; in_valid = 4'b0100;
    step(); chk_out("t4_h0", 2'd1, 4'h9);
    chk("t4_rdy", 32'(in_ready), 32'hB);
    in_valid = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      step(); chk_out("t4_hold", 2'd1, 4'h9);
    end
    out_ready = 1'b1;
    step(); chk_out("t4_next", 2'd2, 4'h7);
    step(); chk("t4_drain", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-cycle with a word presented and two slots full
    do_reset();
    a = 4'h1; b = 4'h2; c = 4'h3; in_valid = 4'b0111; out_ready = 1'b0;
    step();
    in_valid = 4'b0000;
    step(); chk_out("t5_pre", 2'd0, 4'h1);
    chk("t5_pre_rdy", 32'(in_ready), 32'h9);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_async_vld", 32'(out_valid), 32'd0);
    chk("t5_async_rdy", 32'(in_ready), 32'hF);
    chk("t5_async_dat", 32'(out_data), 32'd0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk("t5_no_stale", 32'(out_valid), 32'd0);
    end
    chk("t5_rdy", 32'(in_ready), 32'hF);
    a = 4'h6; b = 4'h7; c = 4'h8; d = 4'h9; in_valid = 4'b1111;
    step();
    in_valid = 4'b0000;
    step(); chk_out("t5_first", 2'd0, 4'h6);

    // Channel 3 alone: one word every 2 cycles, in order
    do_reset();
    d = 4'h1; in_valid = 4'b1000;
    step();
    d = 4'h2;
    step(); chk_out("t6_w0", 2'd3, 4'h1);
    step(); chk("t6_gap0", 32'(out_valid), 32'd0);
    d = 4'h3;
    step(); chk_out("t6_w1", 2'd3, 4'h2);
    step(); chk("t6_gap1", 32'(out_valid), 32'd0);
    step(); chk_out("t6_w2", 2'd3, 4'h3);
    in_valid = 4'b0000;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
